// File: rtl/multi_channel_clk_gen_if.sv
// -----------------------------------------------------------------------------
// multi_channel_clk_gen_if
// Configuration bus for multi_channel_clk_gen.
//   cfg_wr     write strobe, one inclk cycle per write
//   cfg_ch     channel addressed by the write
//   cfg_addr   0 = DIV (period), 1 = HIGH (high cycles), 2 = PHASE, 3 = reserved
//   cfg_wdata  value written into the addressed shadow register
// Modports: master drives the bus (host / testbench), slave receives it (generator).
// -----------------------------------------------------------------------------
interface multi_channel_clk_gen_if #(
  parameter int NUM_CH = 4,
  parameter int CNT_W  = 32
) ();
  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic             cfg_wr;
  logic [CH_W-1:0]  cfg_ch;
  logic [1:0]       cfg_addr;
  logic [CNT_W-1:0] cfg_wdata;

  modport master (
    output cfg_wr,
    output cfg_ch,
    output cfg_addr,
    output cfg_wdata
  );

  modport slave (
    input cfg_wr,
    input cfg_ch,
    input cfg_addr,
    input cfg_wdata
  );
endinterface

// File: rtl/multi_channel_clk_gen.sv
// -----------------------------------------------------------------------------
// multi_channel_clk_gen
// NUM_CH independent programmable clock generators running from inclk. Each
// channel has a programmable period (DIV), high time (HIGH) and sync phase
// (PHASE). Settings are written into shadow registers and copied into the
// active registers only at a period boundary, on sync, or while the channel is
// idle, so a running waveform never glitches.
//
// Ports
//   inclk       source clock, everything on its rising edge
//   Reset       asynchronous, active-low reset
//   ch_en       per-channel run enable (level)
//   sync        one-cycle pulse, re-phases every enabled channel to its PHASE
//   cfg         configuration bus (multi_channel_clk_gen_if.slave)
//   outclk      generated clocks, registered
//   outclk_Not  complement of outclk
//   tick        one-cycle strobe on the cycle each outclk rises
// -----------------------------------------------------------------------------
module multi_channel_clk_gen #(
  parameter int NUM_CH      = 4,
  parameter int CNT_W       = 32,
  parameter int DEFAULT_DIV = 2
) (
  input  logic                     inclk,
  input  logic                     Reset,
  input  logic [NUM_CH-1:0]        ch_en,
  input  logic                     sync,
  multi_channel_clk_gen_if.slave   cfg,
  output logic [NUM_CH-1:0]        outclk,
  output logic [NUM_CH-1:0]        outclk_Not,
  output logic [NUM_CH-1:0]        tick
);

  localparam int CH_W = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  localparam logic [1:0] ADDR_DIV   = 2'd0;
  localparam logic [1:0] ADDR_HIGH  = 2'd1;
  localparam logic [1:0] ADDR_PHASE = 2'd2;

  localparam logic [CNT_W-1:0] RST_DIV  = CNT_W'(DEFAULT_DIV);
  localparam logic [CNT_W-1:0] RST_HIGH = CNT_W'(DEFAULT_DIV / 2);

  // ---------------------------------------------------------------------------
  // Clamping helpers; shadow registers keep the raw written value and these
  // are applied whenever a value is taken into use.
  // ---------------------------------------------------------------------------
  function automatic logic [CNT_W-1:0] clamp_div(input logic [CNT_W-1:0] d);
    return (d < CNT_W'(2)) ? CNT_W'(2) : d;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_high(input logic [CNT_W-1:0] h,
                                                  input logic [CNT_W-1:0] div_c);
    logic [CNT_W-1:0] h1;
    h1 = (h < CNT_W'(1)) ? CNT_W'(1) : h;
    return (h1 > div_c - CNT_W'(1)) ? div_c - CNT_W'(1) : h1;
  endfunction

  function automatic logic [CNT_W-1:0] clamp_phase(input logic [CNT_W-1:0] p,
                                                   input logic [CNT_W-1:0] div_c);
    return (p > div_c - CNT_W'(1)) ? div_c - CNT_W'(1) : p;
  endfunction

  // ---------------------------------------------------------------------------
  // State
  // ---------------------------------------------------------------------------
  logic [CNT_W-1:0] div_s_q   [NUM_CH];
  logic [CNT_W-1:0] div_s_d   [NUM_CH];
  logic [CNT_W-1:0] high_s_q  [NUM_CH];
  logic [CNT_W-1:0] high_s_d  [NUM_CH];
  logic [CNT_W-1:0] phase_s_q [NUM_CH];
  logic [CNT_W-1:0] phase_s_d [NUM_CH];
  logic [CNT_W-1:0] div_a_q   [NUM_CH];
  logic [CNT_W-1:0] div_a_d   [NUM_CH];
  logic [CNT_W-1:0] high_a_q  [NUM_CH];
  logic [CNT_W-1:0] high_a_d  [NUM_CH];
  logic [CNT_W-1:0] cnt_q     [NUM_CH];
  logic [CNT_W-1:0] cnt_d     [NUM_CH];

  // Clamped view of the shadow registers as they stand before this edge.
  logic [CNT_W-1:0] div_c     [NUM_CH];
  logic [CNT_W-1:0] high_c    [NUM_CH];
  logic [CNT_W-1:0] phase_c   [NUM_CH];

  logic [NUM_CH-1:0] outclk_q, outclk_d;
  logic [NUM_CH-1:0] tick_q,   tick_d;
  // Set once a channel has spent an edge in run; clear means the next run
  // edge is the first one after idle or reset.
  logic [NUM_CH-1:0] run_q,    run_d;

  // ---------------------------------------------------------------------------
  // Shadow register writes
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_s_d[i]   = div_s_q[i];
      high_s_d[i]  = high_s_q[i];
      phase_s_d[i] = phase_s_q[i];
      // Addresses beyond NUM_CH-1 never match any i, so they are dropped.
      if (cfg.cfg_wr && (cfg.cfg_ch == CH_W'(i))) begin
        case (cfg.cfg_addr)
          ADDR_DIV:   div_s_d[i]   = cfg.cfg_wdata;
          ADDR_HIGH:  high_s_d[i]  = cfg.cfg_wdata;
          ADDR_PHASE: phase_s_d[i] = cfg.cfg_wdata;
          default:    ;
        endcase
      end
    end
  end

  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_c[i]   = clamp_div(div_s_q[i]);
      high_c[i]  = clamp_high(high_s_q[i], div_c[i]);
      phase_c[i] = clamp_phase(phase_s_q[i], div_c[i]);
    end
  end

  // ---------------------------------------------------------------------------
  // Per-channel counter and waveform
  // ---------------------------------------------------------------------------
  always_comb begin
    for (int i = 0; i < NUM_CH; i++) begin
      div_a_d[i]  = div_a_q[i];
      high_a_d[i] = high_a_q[i];
      cnt_d[i]    = cnt_q[i];
      run_d[i]    = ch_en[i];

      if (!ch_en[i]) begin
        // Idle: keep the active copy tracking the shadow so an enable starts
        // straight away with the latest settings.
        cnt_d[i]    = '0;
        div_a_d[i]  = div_c[i];
        high_a_d[i] = high_c[i];
      end else if (sync) begin
        // sync wins over a wrap landing on the same edge.
        cnt_d[i]    = phase_c[i];
        div_a_d[i]  = div_c[i];
        high_a_d[i] = high_c[i];
      end else if (!run_q[i]) begin
        // First run edge: start the period at cnt=0 so outclk rises at once,
        // independent of the period length.
        cnt_d[i] = '0;
      end else if (cnt_q[i] >= div_a_q[i] - CNT_W'(1)) begin
        cnt_d[i]    = '0;
        div_a_d[i]  = div_c[i];
        high_a_d[i] = high_c[i];
      end else begin
        cnt_d[i] = cnt_q[i] + CNT_W'(1);
      end

      if (ch_en[i]) begin
        outclk_d[i] = (cnt_d[i] < high_a_d[i]);
        tick_d[i]   = (cnt_d[i] == '0);
      end else begin
        outclk_d[i] = 1'b0;
        tick_d[i]   = 1'b0;
      end
    end
  end

  // ---------------------------------------------------------------------------
  // Registers
  // ---------------------------------------------------------------------------
  always_ff @(posedge inclk or negedge Reset) begin
    if (!Reset) begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_s_q[i]   <= RST_DIV;
        high_s_q[i]  <= RST_HIGH;
        phase_s_q[i] <= '0;
        div_a_q[i]   <= RST_DIV;
        high_a_q[i]  <= RST_HIGH;
        cnt_q[i]     <= '0;
      end
      outclk_q <= '0;
      tick_q   <= '0;
      run_q    <= '0;
    end else begin
      for (int i = 0; i < NUM_CH; i++) begin
        div_s_q[i]   <= div_s_d[i];
        high_s_q[i]  <= high_s_d[i];
        phase_s_q[i] <= phase_s_d[i];
        div_a_q[i]   <= div_a_d[i];
        high_a_q[i]  <= high_a_d[i];
        cnt_q[i]     <= cnt_d[i];
      end
      outclk_q <= outclk_d;
      tick_q   <= tick_d;
      run_q    <= run_d;
    end
  end

  assign outclk     = outclk_q;
  assign outclk_Not = ~outclk_q;
  assign tick       = tick_q;

endmodule

// File: tb/tb_multi_channel_clk_gen.sv
// -----------------------------------------------------------------------------
// tb_multi_channel_clk_gen
// Directed bench for multi_channel_clk_gen with three channels (so that
// cfg_ch = NUM_CH is representable). Expected outclk/tick values are pushed
// into a scoreboard queue before each edge and compared just after it.
// -----------------------------------------------------------------------------
module tb_multi_channel_clk_gen;

  localparam int NUM_CH = 3;
  localparam int CNT_W  = 32;
  localparam int CH_W   = (NUM_CH > 1) ? $clog2(NUM_CH) : 1;

  logic              inclk;
  logic              Reset;
  logic [NUM_CH-1:0] ch_en;
  logic              sync;
  logic [NUM_CH-1:0] outclk;
  logic [NUM_CH-1:0] outclk_Not;
  logic [NUM_CH-1:0] tick;

  multi_channel_clk_gen_if #(.NUM_CH(NUM_CH), .CNT_W(CNT_W)) cfg_bus ();

  multi_channel_clk_gen #(
    .NUM_CH      (NUM_CH),
    .CNT_W       (CNT_W),
    .DEFAULT_DIV (2)
  ) dut (
    .inclk      (inclk),
    .Reset      (Reset),
    .ch_en      (ch_en),
    .sync       (sync),
    .cfg        (cfg_bus.slave),
    .outclk     (outclk),
    .outclk_Not (outclk_Not),
    .tick       (tick)
  );

  initial inclk = 1'b0;
  always #5 inclk = ~inclk;

  typedef struct {
    string             tag;
    logic [NUM_CH-1:0] mask;
    logic [NUM_CH-1:0] out;
    logic [NUM_CH-1:0] tck;
  } exp_t;

  exp_t sb[$];
  int   vectors     = 0;
  int   miscompares = 0;

  function automatic logic [NUM_CH-1:0] bitv(input int ch, input logic v);
    logic [NUM_CH-1:0] r;
    r = '0;
    r[ch] = v;
    return r;
  endfunction

  task automatic push(input string tag, input logic [NUM_CH-1:0] mask,
                      input logic [NUM_CH-1:0] out, input logic [NUM_CH-1:0] tck);
    exp_t e;
    e.tag  = tag;
    e.mask = mask;
    e.out  = out;
    e.tck  = tck;
    sb.push_back(e);
  endtask

  task automatic cmp(input string tag, input logic [NUM_CH-1:0] got,
                     input logic [NUM_CH-1:0] exp);
    vectors++;
    assert (got === exp) else begin
      miscompares++;
      $error("FAIL %s: observed %b expected %b", tag, got, exp);
    end
  endtask

  // Compare the current outputs against the oldest scoreboard entry.
  task automatic check_now();
    exp_t e;
    if (sb.size() == 0) begin
      vectors++;
      miscompares++;
      $error("FAIL scoreboard_empty: observed 0 entries expected 1");
    end else begin
      e = sb.pop_front();
      cmp({e.tag, "_outclk"}, outclk & e.mask, e.out & e.mask);
      cmp({e.tag, "_tick"},   tick & e.mask,   e.tck & e.mask);
      cmp({e.tag, "_not"},    outclk_Not,      ~outclk);
    end
  endtask

  task automatic step();
    @(posedge inclk);
    #1;
  endtask

  task automatic step_check();
    step();
    check_now();
  endtask

  // n checked cycles of one channel with counter values start, start+1, ...
  task automatic run_wave(input string tag, input int ch, input int div,
                          input int high, input int start, input int n);
    int c;
    for (int k = 0; k < n; k++) begin
      c = (start + k) % div;
      push(tag, bitv(ch, 1'b1), bitv(ch, c < high), bitv(ch, c == 0));
      step_check();
    end
  endtask

  task automatic cfg_write(input int ch, input int addr, input int data);
    cfg_bus.cfg_wr    = 1'b1;
    cfg_bus.cfg_ch    = CH_W'(ch);
    cfg_bus.cfg_addr  = 2'(addr);
    cfg_bus.cfg_wdata = CNT_W'(data);
    step();
    cfg_bus.cfg_wr    = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: observed timeout expected finish");
    $fatal(1, "bench did not finish");
  end

  initial begin
    logic [NUM_CH-1:0] m, o, t;
    int c0, c2;

    Reset             = 1'b0;
    ch_en             = '0;
    sync              = 1'b0;
    cfg_bus.cfg_wr    = 1'b0;
    cfg_bus.cfg_ch    = '0;
    cfg_bus.cfg_addr  = '0;
    cfg_bus.cfg_wdata = '0;

    // Reset state
    step();
    push("reset", '1, '0, '0);
    check_now();
    step();
    Reset = 1'b1;

    // ch0 at default settings: period 2, one cycle high
    ch_en = 3'b001;
    run_wave("ch0_default", 0, 2, 1, 0, 8);
    ch_en = 3'b000;
    push("ch0_off", '1, '0, '0);
    step_check();

    // ch1 DIV=10 HIGH=3
    cfg_write(1, 0, 10);
    cfg_write(1, 1, 3);
    step();
    ch_en = 3'b010;
    run_wave("ch1_div10", 1, 10, 3, 0, 26);

    // Reprogram DIV=4 at cnt=5: old period finishes, then period 4 high 3
    cfg_bus.cfg_wr    = 1'b1;
    cfg_bus.cfg_ch    = CH_W'(1);
    cfg_bus.cfg_addr  = 2'd0;
    cfg_bus.cfg_wdata = CNT_W'(4);
    run_wave("ch1_old", 1, 10, 3, 6, 1);
    cfg_bus.cfg_wr    = 1'b0;
    run_wave("ch1_old", 1, 10, 3, 7, 3);
    run_wave("ch1_div4", 1, 4, 3, 0, 8);
    ch_en = 3'b000;
    push("ch1_off", '1, '0, '0);
    step_check();

    // Phase alignment: ch0 PHASE=0, ch2 PHASE=4, both DIV=8 HIGH=4
    cfg_write(0, 0, 8);
    cfg_write(0, 1, 4);
    cfg_write(0, 2, 0);
    cfg_write(2, 0, 8);
    cfg_write(2, 1, 4);
    cfg_write(2, 2, 4);
    step();
    ch_en = 3'b101;
    m = 3'b101;
    for (int k = 0; k < 3; k++) begin
      o = (k < 4) ? 3'b101 : 3'b000;
      t = (k == 0) ? 3'b101 : 3'b000;
      push("pre_sync", m, o, t);
      step_check();
    end
    sync = 1'b1;
    for (int k = 0; k < 16; k++) begin
      c0 = k % 8;
      c2 = (k + 4) % 8;
      o = bitv(0, c0 < 4) | bitv(2, c2 < 4);
      t = bitv(0, c0 == 0) | bitv(2, c2 == 0);
      push("phase", m, o, t);
      step_check();
      sync = 1'b0;
    end
    ch_en = 3'b000;
    push("phase_off", '1, '0, '0);
    step_check();

    // Clamping: DIV=0, HIGH=0 gives period 2 high 1
    cfg_write(1, 0, 0);
    cfg_write(1, 1, 0);
    step();
    ch_en = 3'b010;
    run_wave("clamp", 1, 2, 1, 0, 6);

    // Out-of-range channel and reserved address leave everything unchanged
    cfg_bus.cfg_wr    = 1'b1;
    cfg_bus.cfg_ch    = CH_W'(NUM_CH);
    cfg_bus.cfg_addr  = 2'd0;
    cfg_bus.cfg_wdata = CNT_W'(6);
    run_wave("bad_ch", 1, 2, 1, 0, 1);
    cfg_bus.cfg_ch    = CH_W'(1);
    cfg_bus.cfg_addr  = 2'd3;
    run_wave("bad_addr", 1, 2, 1, 1, 1);
    cfg_bus.cfg_wr    = 1'b0;
    run_wave("ignored", 1, 2, 1, 0, 8);
    ch_en = 3'b000;
    push("clamp_off", '1, '0, '0);
    step_check();

    // Reset dropped while ch0 is high and ticking
    ch_en = 3'b001;
    run_wave("rst_pre", 0, 8, 4, 0, 1);
    #2;
    Reset = 1'b0;
    #1;
    push("rst_async", '1, '0, '0);
    check_now();
    ch_en = 3'b000;
    step();
    Reset = 1'b1;
    for (int k = 0; k < 3; k++) begin
      push("rst_idle", '1, '0, '0);
      step_check();
    end
    // Configuration is back at defaults after reset
    ch_en = 3'b001;
    run_wave("post_rst", 0, 2, 1, 0, 6);

    $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
    $finish;
  end

endmodule
